// File: rtl/uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_bridge
//  Purpose  : Byte-stream command engine. Two-byte commands (opcode, operand)
//             arriving on a UART-style byte interface drive output byte lanes,
//             sample input lanes, access a scratch register file (uw / ur)
//             and perform single-word memory reads/writes with a timeout.
//             Results go back over a valid/ready TX byte port.
//  Ports    : sys_clk, sys_rst          - clock, synchronous active-high reset
//             rx_valid, rx_data         - incoming byte strobe and data
//             tx_valid, tx_data, tx_ready - outgoing byte handshake
//             out_clk, out_rst          - software-driven control lines
//             in_pins, out_pins         - N_PINS byte lanes each direction
//             mem_addr, mem_wdata, mem_rdata,
//             mem_rd_req/ack, mem_wr_req/ack - single-word memory bus
//             busy                      - FSM is not idle
//  Options  : `define UART_CMD_BRIDGE_FRAME_TIMEOUT_EN to discard a pending
//             opcode after 2^20 cycles without an operand.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_bridge #(
   parameter int N_PINS      = 8,
   parameter int N_REGS      = 8,
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                rx_valid,
   input  logic [7:0]          rx_data,
   output logic                tx_valid,
   output logic [7:0]          tx_data,
   input  logic                tx_ready,
   output logic                out_clk,
   output logic                out_rst,
   input  logic [8*N_PINS-1:0] in_pins,
   output logic [8*N_PINS-1:0] out_pins,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_rd_req,
   input  logic                mem_rd_ack,
   output logic                mem_wr_req,
   input  logic                mem_wr_ack,
   output logic                busy
);

   localparam int          c_NB      = DATA_W / 8;
   localparam logic [15:0] c_TIMEOUT = 16'(MEM_TIMEOUT);

   localparam logic [2:0] c_S_IDLE     = 3'd0;
   localparam logic [2:0] c_S_EXEC     = 3'd1;
   localparam logic [2:0] c_S_TX_WAIT  = 3'd2;
   localparam logic [2:0] c_S_MEM_REQ  = 3'd3;
   localparam logic [2:0] c_S_MEM_WAIT = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic                r_have_op;
   logic [7:0]          r_opcode;
   logic [7:0]          r_operand;
   logic [8*N_PINS-1:0] r_out_pins;
   logic                r_out_clk;
   logic                r_out_rst;
   logic [7:0]          r_tx_data;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_is_read;
   logic [15:0]         r_cnt;
   logic                r_timeout_err;
   logic                r_overrun;
   logic [7:0]          r_uw [N_REGS];
   logic [7:0]          r_ur [N_REGS];
`ifdef UART_CMD_BRIDGE_FRAME_TIMEOUT_EN
   logic [19:0]         r_frame_cnt;
`endif

   logic [3:0] w_hi;
   logic [3:0] w_n;
   logic       w_rx_accept;
   logic       w_is_send;
   logic       w_is_mem;
   logic [7:0] w_tx_byte;
   logic       w_ack;
   logic       w_mem_pending;

   assign w_hi          = r_opcode[7:4];
   assign w_n           = r_opcode[3:0];
   // Bytes are only taken while idle; anything arriving while busy is an overrun.
   assign w_rx_accept   = rx_valid && (r_state == c_S_IDLE);
   assign w_is_mem      = (r_opcode == 8'hA0) || (r_opcode == 8'hA1);
   assign w_ack         = r_is_read ? mem_rd_ack : mem_wr_ack;
   assign w_mem_pending = (r_state == c_S_MEM_REQ) || (r_state == c_S_MEM_WAIT);

   // Selects the reply byte for send opcodes; out-of-range lanes/regs never match.
   always_comb begin
      w_tx_byte = 8'h00;
      w_is_send = 1'b0;
      case (w_hi)
         4'h2: begin
            for (int i = 0; i < N_PINS; i++) begin
               if (w_n == 4'(i)) begin
                  w_tx_byte = in_pins[8*i +: 8];
                  w_is_send = 1'b1;
               end
            end
         end
         4'h5: begin
            for (int i = 0; i < N_REGS; i++) begin
               if (w_n == 4'(i)) begin
                  w_tx_byte = r_ur[i];
                  w_is_send = 1'b1;
               end
            end
         end
         4'hB: begin
            if (w_n == 4'h0) begin
               w_tx_byte = {5'b0, r_timeout_err, r_overrun, w_mem_pending};
               w_is_send = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (w_rx_accept && r_have_op) w_next_state = c_S_EXEC;
         end
         c_S_EXEC: begin
            if (w_is_send)     w_next_state = c_S_TX_WAIT;
            else if (w_is_mem) w_next_state = c_S_MEM_REQ;
            else               w_next_state = c_S_IDLE;
         end
         c_S_TX_WAIT: begin
            if (tx_ready) w_next_state = c_S_IDLE;
         end
         c_S_MEM_REQ: w_next_state = c_S_MEM_WAIT;
         c_S_MEM_WAIT: begin
            if (w_ack || (r_cnt == c_TIMEOUT)) w_next_state = c_S_IDLE;
         end
         default: w_next_state = c_S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy       = (r_state != c_S_IDLE);
      tx_valid   = (r_state == c_S_TX_WAIT);
      mem_rd_req = (r_state == c_S_MEM_WAIT) &&  r_is_read;
      mem_wr_req = (r_state == c_S_MEM_WAIT) && !r_is_read;
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_have_op     <= 1'b0;
         r_opcode      <= '0;
         r_operand     <= '0;
         r_out_pins    <= '0;
         r_out_clk     <= 1'b0;
         r_out_rst     <= 1'b0;
         r_tx_data     <= '0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_is_read     <= 1'b0;
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
         r_overrun     <= 1'b0;
         for (int i = 0; i < N_REGS; i++) begin
            r_uw[i] <= '0;
            r_ur[i] <= '0;
         end
`ifdef UART_CMD_BRIDGE_FRAME_TIMEOUT_EN
         r_frame_cnt   <= '0;
`endif
      end else begin
`ifdef UART_CMD_BRIDGE_FRAME_TIMEOUT_EN
         // A stale opcode is dropped once the counter wraps; an operand
         // arriving in that same cycle still wins (assigned below).
         if (!r_have_op) begin
            r_frame_cnt <= '0;
         end else if (r_frame_cnt == '1) begin
            r_frame_cnt <= '0;
            r_have_op   <= 1'b0;
         end else begin
            r_frame_cnt <= r_frame_cnt + 20'd1;
         end
`endif
         // Framing: a zero first byte is treated as line noise and ignored.
         if (w_rx_accept) begin
            if (r_have_op) begin
               r_operand <= rx_data;
               r_have_op <= 1'b0;
            end else if (rx_data != 8'h00) begin
               r_opcode  <= rx_data;
               r_have_op <= 1'b1;
            end
         end

         if (r_state == c_S_EXEC) begin
            if (w_is_send) r_tx_data <= w_tx_byte;
            case (w_hi)
               4'h1: begin
                  case (w_n)
                     4'h0:    r_out_clk <= 1'b1;
                     4'h1:    r_out_clk <= 1'b0;
                     4'h2:    r_out_rst <= 1'b1;
                     4'h3:    r_out_rst <= 1'b0;
                     default: ;
                  endcase
               end
               4'h3: begin
                  for (int i = 0; i < N_PINS; i++) begin
                     if (w_n == 4'(i)) r_out_pins[8*i +: 8] <= r_operand;
                  end
               end
               4'h4: begin
                  for (int i = 0; i < N_REGS; i++) begin
                     if (w_n == 4'(i)) r_uw[i] <= r_operand;
                  end
               end
               4'hA: begin
                  if (w_is_mem) begin
                     r_is_read <= w_n[0];
                     r_cnt     <= '0;
                     // Address comes from uw[7:4], data from uw[3:0], little-endian.
                     for (int b = 0; b < ADDR_W; b++) r_mem_addr[b]  <= r_uw[4 + b/8][b%8];
                     for (int b = 0; b < DATA_W; b++) r_mem_wdata[b] <= r_uw[b/8][b%8];
                  end
               end
               4'hB: begin
                  if (w_n == 4'h0) begin
                     r_timeout_err <= 1'b0;
                     r_overrun     <= 1'b0;
                  end
               end
               default: ;
            endcase
         end

         if (r_state == c_S_MEM_WAIT) begin
            if (w_ack) begin
               // ur[7] reports the ack latency, saturated to one byte.
               r_ur[7] <= (r_cnt > 16'd255) ? 8'hFF : r_cnt[7:0];
               if (r_is_read) begin
                  for (int b = 0; b < c_NB; b++) r_ur[b] <= mem_rdata[8*b +: 8];
               end
            end else if (r_cnt == c_TIMEOUT) begin
               r_timeout_err <= 1'b1;
               r_ur[7]       <= 8'hFF;
            end else begin
               r_cnt <= r_cnt + 16'd1;
            end
         end

         // Placed last so a new overrun is never lost to a status-read clear.
         if (rx_valid && (r_state != c_S_IDLE)) r_overrun <= 1'b1;
      end
   end

   assign out_pins  = r_out_pins;
   assign out_clk   = r_out_clk;
   assign out_rst   = r_out_rst;
   assign tx_data   = r_tx_data;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_bridge
//  Purpose  : Self-checking bench for uart_cmd_bridge. A byte-level command
//             interpreter model predicts pins, registers, replies and
//             memory traffic; directed cases plus a randomized command stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_bridge;
   localparam int N_PINS      = 8;
   localparam int N_REGS      = 8;
   localparam int ADDR_W      = 24;
   localparam int DATA_W      = 16;
   localparam int MEM_TIMEOUT = 255;
   localparam int NEVER       = 100000;

   logic                sys_clk = 1'b0;
   logic                sys_rst = 1'b1;
   logic                rx_valid = 1'b0;
   logic [7:0]          rx_data = 8'h00;
   logic                tx_valid;
   logic [7:0]          tx_data;
   logic                tx_ready = 1'b0;
   logic                out_clk;
   logic                out_rst;
   logic [8*N_PINS-1:0] in_pins = '0;
   logic [8*N_PINS-1:0] out_pins;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata = '0;
   logic                mem_rd_req;
   logic                mem_rd_ack = 1'b0;
   logic                mem_wr_req;
   logic                mem_wr_ack = 1'b0;
   logic                busy;

   always #5 sys_clk = ~sys_clk;

   uart_cmd_bridge #(
      .N_PINS(N_PINS), .N_REGS(N_REGS), .ADDR_W(ADDR_W),
      .DATA_W(DATA_W), .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .out_clk(out_clk), .out_rst(out_rst),
      .in_pins(in_pins), .out_pins(out_pins),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
      .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
      .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [7:0] m_pins [N_PINS];
   logic [7:0] m_uw   [N_REGS];
   logic [7:0] m_ur   [N_REGS];
   logic       m_clk, m_rst, m_terr, m_ovr, m_have_op;
   logic [7:0] m_op;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_PINS; i++) m_pins[i] = 8'h00;
      for (int i = 0; i < N_REGS; i++) begin
         m_uw[i] = 8'h00;
         m_ur[i] = 8'h00;
      end
      m_clk = 0; m_rst = 0; m_terr = 0; m_ovr = 0; m_have_op = 0; m_op = 8'h00;
   endtask

   task automatic chk_outputs(input string tag);
      for (int i = 0; i < N_PINS; i++) chk_val({tag, "_pin"}, out_pins[8*i +: 8], m_pins[i]);
      chk_val({tag, "_out_clk"}, out_clk, m_clk);
      chk_val({tag, "_out_rst"}, out_rst, m_rst);
      chk_val({tag, "_tx_valid"}, tx_valid, 1'b0);
      chk_val({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic chk_reset_state();
      chk_val("rst_busy", busy, 0);
      chk_val("rst_tx_valid", tx_valid, 0);
      chk_val("rst_tx_data", tx_data, 0);
      chk_val("rst_out_pins", out_pins, 0);
      chk_val("rst_out_clk", out_clk, 0);
      chk_val("rst_out_rst", out_rst, 0);
      chk_val("rst_mem_addr", mem_addr, 0);
      chk_val("rst_mem_wdata", mem_wdata, 0);
      chk_val("rst_rd_req", mem_rd_req, 0);
      chk_val("rst_wr_req", mem_wr_req, 0);
   endtask

   // Executes one complete command from the model's point of view and plays
   // the sink / memory side of the handshake while the DUT is busy.
   task automatic exec_cmd(input logic [7:0] op, input logic [7:0] opd, input int ack_delay,
                           input int ready_delay, input int inject_at, input logic [DATA_W-1:0] rd_val);
      int         hi, ni, stall, req_cnt, unstable;
      bit         exp_tx, exp_mem, exp_rd, got_tx, saw_rd, saw_wr, timed;
      logic [7:0] exp_byte, got_byte;
      logic [31:0] word_a, word_d;
      logic [ADDR_W-1:0] got_addr;
      logic [DATA_W-1:0] got_wdata;
      hi = int'(op[7:4]);
      ni = int'(op[3:0]);
      exp_tx = 0; exp_mem = 0; exp_rd = 0; exp_byte = 8'h00; got_byte = 8'h00;
      word_a = m_uw[4] + (32'(m_uw[5]) << 8) + (32'(m_uw[6]) << 16) + (32'(m_uw[7]) << 24);
      word_d = m_uw[0] + (32'(m_uw[1]) << 8) + (32'(m_uw[2]) << 16) + (32'(m_uw[3]) << 24);
      if (op == 8'h10) m_clk = 1;
      if (op == 8'h11) m_clk = 0;
      if (op == 8'h12) m_rst = 1;
      if (op == 8'h13) m_rst = 0;
      if (hi == 2 && ni < N_PINS) begin exp_tx = 1; exp_byte = in_pins[8*ni +: 8]; end
      if (hi == 3 && ni < N_PINS) m_pins[ni] = opd;
      if (hi == 4 && ni < N_REGS) m_uw[ni] = opd;
      if (hi == 5 && ni < N_REGS) begin exp_tx = 1; exp_byte = m_ur[ni]; end
      if (op == 8'hA0 || op == 8'hA1) begin
         exp_mem = 1;
         exp_rd  = op[0];
         if (ack_delay < MEM_TIMEOUT) begin
            m_ur[7] = (ack_delay > 255) ? 8'hFF : 8'(ack_delay);
            if (exp_rd) for (int b = 0; b < DATA_W/8; b++) m_ur[b] = 8'(rd_val >> (8*b));
         end else begin
            m_terr  = 1;
            m_ur[7] = 8'hFF;
         end
      end
      if (op == 8'hB0) begin
         exp_tx = 1;
         exp_byte = {5'b0, m_terr, m_ovr, 1'b0};
         m_terr = 0; m_ovr = 0;
      end
      if (exp_tx && inject_at >= 0 && inject_at <= ready_delay) m_ovr = 1;

      got_tx = 0; stall = 0; req_cnt = 0; unstable = 0; saw_rd = 0; saw_wr = 0; timed = 1;
      got_addr = '0; got_wdata = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         mem_rd_ack = 0; mem_wr_ack = 0; tx_ready = 0; rx_valid = 0;
         mem_rdata = DATA_W'($urandom);
         if (mem_rd_req || mem_wr_req) begin
            saw_rd |= mem_rd_req;
            saw_wr |= mem_wr_req;
            got_addr = mem_addr;
            got_wdata = mem_wdata;
            if (req_cnt == ack_delay) begin
               if (mem_rd_req) begin mem_rd_ack = 1; mem_rdata = rd_val; end
               else mem_wr_ack = 1;
            end
            req_cnt++;
         end else begin
            // stray acks with no request outstanding must be ignored
            mem_rd_ack = ($urandom_range(0, 4) == 0);
            mem_wr_ack = ($urandom_range(0, 4) == 0);
         end
         if (tx_valid) begin
            if (stall == 0) got_byte = tx_data;
            else if (tx_data !== got_byte) unstable++;
            if (stall == inject_at) begin rx_valid = 1; rx_data = 8'h20; end
            if (stall >= ready_delay) begin tx_ready = 1; got_tx = 1; end
            stall++;
         end
         tick();
         if (!busy) begin timed = 0; break; end
      end
      mem_rd_ack = 0; mem_wr_ack = 0; tx_ready = 0; rx_valid = 0;

      chk_val("cmd_completes", timed, 0);
      chk_val("tx_sent", got_tx, exp_tx);
      if (exp_tx) begin
         chk_val("tx_byte", got_byte, exp_byte);
         chk_val("tx_stable", unstable, 0);
      end
      chk_val("rd_req_seen", saw_rd, exp_mem && exp_rd);
      chk_val("wr_req_seen", saw_wr, exp_mem && !exp_rd);
      if (exp_mem) begin
         chk_val("mem_addr", got_addr, word_a[ADDR_W-1:0]);
         chk_val("mem_wdata", got_wdata, word_d[DATA_W-1:0]);
         chk_val("req_cycles", req_cnt, (ack_delay < MEM_TIMEOUT) ? ack_delay + 1 : MEM_TIMEOUT + 1);
      end
      chk_outputs("post_cmd");
   endtask

   task automatic feed(input logic [7:0] b, input int ack_delay = 3, input int ready_delay = 0,
                       input int inject_at = -1, input logic [DATA_W-1:0] rd_val = '0);
      bit         complete;
      logic [7:0] op;
      complete = 0;
      op = m_op;
      if (!m_have_op) begin
         if (b != 8'h00) begin m_have_op = 1; m_op = b; end
      end else begin
         complete = 1;
         m_have_op = 0;
      end
      rx_valid = 1; rx_data = b;
      tick();
      rx_valid = 0; rx_data = 8'($urandom);
      if (complete) exec_cmd(op, b, ack_delay, ready_delay, inject_at, rd_val);
      else chk_val("idle_after_byte", busy, 0);
   endtask

   task automatic do_reset();
      sys_rst = 1;
      tick();
      chk_reset_state();
      tick();
      sys_rst = 0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      int hi_tab [9] = '{1, 2, 3, 4, 5, 10, 11, 7, 15};
      model_reset();
      tick();
      do_reset();

      // lane write and its two-cycle latency
      feed(8'h33);
      m_have_op = 0;
      rx_valid = 1; rx_data = 8'h5A;
      tick();
      rx_valid = 0;
      chk_val("lane3_one_cycle", out_pins[31:24], 8'h00);
      tick();
      chk_val("lane3_two_cycles", out_pins[31:24], 8'h5A);
      m_pins[3] = 8'h5A;
      chk_outputs("lane3");

      // input lane read with a stalled sink
      in_pins[23:16] = 8'hC3;
      feed(8'h22); feed(8'h00, 3, 10);

      // scratch regs, memory write then read
      feed(8'h40); feed(8'h34);
      feed(8'h41); feed(8'h12);
      for (int i = 2; i < 8; i++) begin
         feed(8'h40 + 8'(i)); feed((i == 4) ? 8'h10 : 8'h00);
      end
      feed(8'hA0); feed(8'h00, 5);
      feed(8'hA1); feed(8'h00, 5, 0, -1, 16'hBEEF);
      feed(8'h50); feed(8'h00);
      feed(8'h51); feed(8'h00);
      feed(8'h57); feed(8'h00);

      // read timeout, then status twice
      feed(8'hA1); feed(8'h00, NEVER);
      feed(8'h57); feed(8'h00);
      feed(8'hB0); feed(8'h00);
      feed(8'hB0); feed(8'h00);

      // overrun during a stalled reply, then status and framing
      feed(8'h22); feed(8'h00, 3, 8, 3);
      feed(8'hB0); feed(8'h00);
      feed(8'h35); feed(8'h99);
      // byte arriving on the very cycle the reply is accepted
      feed(8'h50); feed(8'h00, 3, 4, 4);
      feed(8'hB0); feed(8'h00);

      // leading zero is ignored
      feed(8'h00); feed(8'h36); feed(8'h44);

      // pending opcode survives a long silence
      feed(8'h31);
      repeat (3000) tick();
      feed(8'h31); feed(8'h77);
      feed(8'h00);

      // randomized command stream
      for (int k = 0; k < 220; k++) begin
         logic [7:0] op, opd;
         int         ad, rdy, inj, pick;
         if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < N_PINS; i++) in_pins[8*i +: 8] = 8'($urandom);
         op[7:4] = 4'(hi_tab[$urandom_range(0, 8)]);
         op[3:0] = (op[7:4] >= 4'hA) ? 4'($urandom_range(0, 2)) : 4'($urandom);
         opd = 8'($urandom);
         pick = $urandom_range(0, 9);
         ad = (pick == 0) ? NEVER : (pick == 1) ? 254 : $urandom_range(0, 20);
         rdy = $urandom_range(0, 4);
         inj = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rdy) : -1;
         feed(op);
         repeat ($urandom_range(0, 3)) tick();
         feed(opd, ad, rdy, inj, DATA_W'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      // reset in the middle of a memory request
      feed(8'hA1);
      m_have_op = 0;
      rx_valid = 1; rx_data = 8'h00;
      tick();
      rx_valid = 0;
      tick(); tick();
      chk_val("midop_rd_req_high", mem_rd_req, 1);
      do_reset();

      // reset in the middle of a reply
      feed(8'h25);
      m_have_op = 0;
      rx_valid = 1; rx_data = 8'h00;
      tick();
      rx_valid = 0;
      tick();
      chk_val("midop_tx_valid_high", tx_valid, 1);
      do_reset();
      feed(8'h57); feed(8'h00);
      feed(8'h32); feed(8'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
